// File: rtl/an_rx_ds_demod.sv
// Sinc2 CIC decimator for a 1-bit delta-sigma stream, followed by a hysteretic
// zero-crossing detector that measures the tone period in PCM samples.
module an_rx_ds_demod #(
  parameter int C_DECIM_LOG2 = 8,
  parameter int C_HYST       = 2**(2*C_DECIM_LOG2-4),
  parameter int C_PER_W      = 16
) (
  input  logic                    CK_i,
  input  logic                    RST_i,
  input  logic                    DS_i,
  output logic [2*C_DECIM_LOG2:0] PCMs_o,
  output logic                    PCM_STB_o,
  output logic [C_PER_W-1:0]      PERIODs_o,
  output logic                    PER_STB_o,
  output logic                    NO_TONE_o
);

  localparam int W = 2*C_DECIM_LOG2 + 1;
  localparam int D = 2**C_DECIM_LOG2;
  localparam logic [W-1:0] HI_TH = W'(D*D/2 + C_HYST);
  localparam logic [W-1:0] LO_TH = W'(D*D/2 - C_HYST);
  localparam logic [C_DECIM_LOG2-1:0] DEC_ONE = 1;
  localparam logic [C_DECIM_LOG2-1:0] DEC_MAX = '1;
  localparam logic [C_PER_W-1:0] PER_ONE = 1;
  localparam logic [C_PER_W-1:0] PER_MAX = '1;

  typedef enum logic {ST_LOW, ST_HIGH} det_state_t;

  function automatic logic [C_PER_W-1:0] sat_inc(input logic [C_PER_W-1:0] v);
    return (v == PER_MAX) ? v : v + PER_ONE;
  endfunction

  logic                    ds_meta, ds_s;
  logic [W-1:0]            i1_p0, i2_p0;
  logic [C_DECIM_LOG2-1:0] dec_ctr;
  logic [1:0]              warm_ctr;
  logic                    evt_p0;
  logic [W-1:0]            c1_p1, i2_d;
  logic                    evt_p1, vld_p1;
  logic [W-1:0]            pcm_p2, c1_d;
  logic                    vld_p2;

  det_state_t              state_q, state_d;
  logic                    rise;
  logic                    armed_q;
  logic [C_PER_W-1:0]      per_ctr, per_inc, period_q;
  logic                    per_stb_q, no_tone_q;

  assign evt_p0  = (dec_ctr == DEC_MAX);
  assign per_inc = sat_inc(per_ctr);

  // All CIC arithmetic wraps modulo 2^W; the combs undo the integrator wrap.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      ds_meta  <= 1'b0;
      ds_s     <= 1'b0;
      i1_p0    <= '0;
      i2_p0    <= '0;
      dec_ctr  <= '0;
      warm_ctr <= '0;
      evt_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      c1_p1    <= '0;
      i2_d     <= '0;
      vld_p2   <= 1'b0;
      pcm_p2   <= '0;
      c1_d     <= '0;
    end else begin
      ds_meta <= DS_i;
      ds_s    <= ds_meta;
      i1_p0   <= i1_p0 + {{(W-1){1'b0}}, ds_s};
      i2_p0   <= i2_p0 + i1_p0;
      dec_ctr <= dec_ctr + DEC_ONE;
      // p0 -> p1: first comb at the decimation event
      evt_p1  <= evt_p0;
      vld_p1  <= evt_p0 && (warm_ctr == 2'd2);
      if (evt_p0) begin
        c1_p1 <= i2_p0 - i2_d;
        i2_d  <= i2_p0;
        if (warm_ctr != 2'd2) warm_ctr <= warm_ctr + 2'd1;
      end
      // p1 -> p2: second comb and PCM output register
      vld_p2 <= vld_p1;
      if (evt_p1) c1_d <= c1_p1;
      if (vld_p1) pcm_p2 <= c1_p1 - c1_d;
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) state_q <= ST_LOW;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    if (vld_p2) begin
      unique case (state_q)
        ST_LOW:  if (pcm_p2 > HI_TH) begin
                   state_d = ST_HIGH;
                   rise    = 1'b1;
                 end
        ST_HIGH: if (pcm_p2 < LO_TH) state_d = ST_LOW;
        default: state_d = ST_LOW;
      endcase
    end
  end

  // The first rising crossing only arms; each later one reports a period.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      armed_q   <= 1'b0;
      per_ctr   <= '0;
      period_q  <= '0;
      per_stb_q <= 1'b0;
      no_tone_q <= 1'b1;
    end else begin
      per_stb_q <= 1'b0;
      if (vld_p2) begin
        if (rise) begin
          per_ctr <= '0;
          armed_q <= 1'b1;
          if (armed_q) begin
            period_q  <= per_inc;
            per_stb_q <= 1'b1;
            no_tone_q <= 1'b0;
          end
        end else begin
          per_ctr <= per_inc;
          if (per_inc == PER_MAX) begin
            no_tone_q <= 1'b1;
            armed_q   <= 1'b0;
          end
        end
      end
    end
  end

  assign PCMs_o    = pcm_p2;
  assign PCM_STB_o = vld_p2;
  assign PERIODs_o = period_q;
  assign PER_STB_o = per_stb_q;
  assign NO_TONE_o = no_tone_q;

endmodule

// File: tb/tb_an_rx_ds_demod.sv
// Bench for an_rx_ds_demod: D-periodic bit patterns give alignment-free expected
// PCM values (D * ones per period); square waves give exact tone periods.
module tb_an_rx_ds_demod;

  localparam int L    = 4;
  localparam int PW   = 10;
  localparam int D    = 16;
  localparam int SATN = 1023;

  logic          CK_i = 1'b0;
  logic          RST_i = 1'b1;
  logic          DS_i = 1'b0;
  logic [2*L:0]  PCMs_o;
  logic          PCM_STB_o;
  logic [PW-1:0] PERIODs_o;
  logic          PER_STB_o;
  logic          NO_TONE_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int half = 1600;
  logic [15:0] pat = '0, pat_hi = '1, pat_lo = '0;

  an_rx_ds_demod #(.C_DECIM_LOG2(L), .C_PER_W(PW)) dut (
    .CK_i(CK_i), .RST_i(RST_i), .DS_i(DS_i),
    .PCMs_o(PCMs_o), .PCM_STB_o(PCM_STB_o),
    .PERIODs_o(PERIODs_o), .PER_STB_o(PER_STB_o), .NO_TONE_o(NO_TONE_o)
  );

  always #5 CK_i = ~CK_i;

  // mode 0/1: constant, 2: repeating 16-bit pattern, 3: square wave of two patterns
  function automatic logic ds_gen(input int c);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return pat[c % 16];
      default: return (((c / half) % 2) == 1) ? pat_hi[c % 16] : pat_lo[c % 16];
    endcase
  endfunction

  function automatic logic [15:0] pat_k(input int k);
    logic [15:0] p = '0;
    while ($countones(p) < k) p[$urandom_range(15, 0)] = 1'b1;
    return p;
  endfunction

  task automatic step();
    @(negedge CK_i);
    cyc++;
    DS_i = ds_gen(cyc);
  endtask

  task automatic do_reset();
    cyc = 0;
    RST_i = 1'b1;
    step();
    step();
    RST_i = 1'b0;
  endtask

  task automatic wait_pcm(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      if (PCM_STB_o === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    mode = 1;
    RST_i = 1'b1;
    repeat (3) step();
    checks++; if (PCMs_o !== 9'd0)     begin errors++; $display("FAIL reset_pcm got %0d want 0", PCMs_o); end
    checks++; if (PCM_STB_o !== 1'b0)  begin errors++; $display("FAIL reset_pcm_stb got %b want 0", PCM_STB_o); end
    checks++; if (PERIODs_o !== 10'd0) begin errors++; $display("FAIL reset_period got %0d want 0", PERIODs_o); end
    checks++; if (PER_STB_o !== 1'b0)  begin errors++; $display("FAIL reset_per_stb got %b want 0", PER_STB_o); end
    checks++; if (NO_TONE_o !== 1'b1)  begin errors++; $display("FAIL reset_no_tone got %b want 1", NO_TONE_o); end
  endtask

  task automatic test_warmup();
    int first = 0;
    int early_bad = 0;
    mode = 1;
    do_reset();
    for (int k = 1; k <= 64 && first == 0; k++) begin
      step();
      if (PCM_STB_o === 1'b1) first = k;
      else if (PCMs_o !== 9'd0) early_bad++;
    end
    checks++; if (first < 3*D || first > 3*D+4) begin errors++; $display("FAIL first_strobe got cycle %0d want %0d..%0d", first, 3*D, 3*D+4); end
    checks++; if (early_bad != 0) begin errors++; $display("FAIL warmup_pcm got %0d nonzero samples want 0", early_bad); end
    checks++; if (PCMs_o !== 9'd256) begin errors++; $display("FAIL first_pcm got %0d want 256", PCMs_o); end
    // 40 strobes x 16 cycles spans several integrator wraps
    for (int s = 0; s < 40; s++) begin
      int gap = 0;
      bit got = 1'b0;
      while (!got && gap < 64) begin
        step();
        gap++;
        if (PCM_STB_o === 1'b1) got = 1'b1;
      end
      checks++; if (!got || gap != D) begin errors++; $display("FAIL strobe_gap got %0d want %0d", gap, D); end
      checks++; if (PCMs_o !== 9'd256) begin errors++; $display("FAIL const1_pcm strobe %0d got %0d want 256", s, PCMs_o); end
    end
  endtask

  task automatic test_density();
    logic [15:0] pl [8];
    pl[0] = 16'h0000;
    pl[1] = 16'h5555;
    for (int i = 2; i < 8; i++) pl[i] = 16'($urandom);
    mode = 2;
    for (int i = 0; i < 8; i++) begin
      int exp_v;
      bit got;
      pat = pl[i];
      exp_v = D * $countones(pl[i]);
      repeat (3) wait_pcm(got);
      for (int s = 0; s < 4; s++) begin
        wait_pcm(got);
        checks++;
        if (!got || PCMs_o !== 9'(exp_v)) begin
          errors++;
          $display("FAIL density_pcm pat %h got %0d want %0d", pl[i], PCMs_o, exp_v);
        end
      end
    end
  endtask

  task automatic test_period();
    int s = 0;
    int nper = 0;
    int first_s = 0;
    logic prev = 1'b0;
    mode = 3; half = 1600; pat_hi = 16'hFFFF; pat_lo = 16'h0000;
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      step();
      if (PER_STB_o === 1'b1) begin
        nper++;
        if (nper == 1) first_s = s;
        checks++; if (PERIODs_o !== 10'd200) begin errors++; $display("FAIL period_val got %0d want 200", PERIODs_o); end
        checks++; if (NO_TONE_o !== 1'b0)    begin errors++; $display("FAIL period_no_tone got %b want 0", NO_TONE_o); end
        checks++; if (prev !== 1'b1)         begin errors++; $display("FAIL per_stb_align got prev pcm_stb %b want 1", prev); end
      end
      prev = PCM_STB_o;
      if (PCM_STB_o === 1'b1) s++;
    end
    checks++; if (nper != 2)     begin errors++; $display("FAIL period_count got %0d want 2", nper); end
    checks++; if (first_s < 250) begin errors++; $display("FAIL period_arm_only got first report at sample %0d want >=250", first_s); end
  endtask

  task automatic test_dropout();
    bit got = 1'b0;
    bit stop = 1'b0;
    int s = 0;
    int nt_early = 0;
    int extra = 0;
    for (int k = 0; k < 3400 && !got; k++) begin
      step();
      if (PER_STB_o === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL dropout_sync got no PER_STB want one"); end
    mode = 0;
    for (int n = 1; n <= SATN + 2 && !stop; n++) begin
      bit g;
      logic exp_nt;
      wait_pcm(g);
      if (!g) begin
        stop = 1'b1;
        checks++; errors++; $display("FAIL dropout_timeout got no PCM strobe want one");
      end else begin
        step();
        if (PER_STB_o !== 1'b0) extra++;
        exp_nt = (n >= SATN);
        checks++;
        if (NO_TONE_o !== exp_nt) begin errors++; $display("FAIL dropout_no_tone sample %0d got %b want %b", n, NO_TONE_o, exp_nt); end
      end
    end
    checks++; if (extra != 0)             begin errors++; $display("FAIL dropout_per_stb got %0d want 0", extra); end
    checks++; if (PERIODs_o !== 10'd200)  begin errors++; $display("FAIL dropout_hold got %0d want 200", PERIODs_o); end
    mode = 3; cyc = 0; got = 1'b0;
    for (int k = 0; k < 8000 && !got; k++) begin
      step();
      if (PER_STB_o === 1'b1) begin
        got = 1'b1;
        checks++; if (PERIODs_o !== 10'd200) begin errors++; $display("FAIL restore_period got %0d want 200", PERIODs_o); end
        checks++; if (NO_TONE_o !== 1'b0)    begin errors++; $display("FAIL restore_no_tone got %b want 0", NO_TONE_o); end
        checks++; if (s < 150)               begin errors++; $display("FAIL restore_rearm got report at sample %0d want >=150", s); end
      end else if (NO_TONE_o !== 1'b1) nt_early++;
      if (PCM_STB_o === 1'b1) s++;
    end
    checks++; if (!got)          begin errors++; $display("FAIL restore_timeout got no PER_STB want one"); end
    checks++; if (nt_early != 0) begin errors++; $display("FAIL restore_no_tone_early got %0d cycles low want 0", nt_early); end
  endtask

  task automatic test_midreset();
    int first = 0;
    int s = 0;
    bit got = 1'b0;
    repeat (2400) step();
    RST_i = 1'b1;
    step();
    checks++; if (PCMs_o !== 9'd0)     begin errors++; $display("FAIL midrst_pcm got %0d want 0", PCMs_o); end
    checks++; if (PCM_STB_o !== 1'b0)  begin errors++; $display("FAIL midrst_pcm_stb got %b want 0", PCM_STB_o); end
    checks++; if (PERIODs_o !== 10'd0) begin errors++; $display("FAIL midrst_period got %0d want 0", PERIODs_o); end
    checks++; if (PER_STB_o !== 1'b0)  begin errors++; $display("FAIL midrst_per_stb got %b want 0", PER_STB_o); end
    checks++; if (NO_TONE_o !== 1'b1)  begin errors++; $display("FAIL midrst_no_tone got %b want 1", NO_TONE_o); end
    RST_i = 1'b0;
    for (int k = 1; k <= 64 && first == 0; k++) begin
      step();
      if (PCM_STB_o === 1'b1) first = k;
    end
    checks++; if (first < 3*D || first > 3*D+4) begin errors++; $display("FAIL midrst_first_strobe got cycle %0d want %0d..%0d", first, 3*D, 3*D+4); end
    for (int k = 0; k < 8000 && !got; k++) begin
      step();
      if (PER_STB_o === 1'b1) begin
        got = 1'b1;
        checks++; if (PERIODs_o !== 10'd200) begin errors++; $display("FAIL midrst_period_val got %0d want 200", PERIODs_o); end
        checks++; if (s < 150)               begin errors++; $display("FAIL midrst_rearm got report at sample %0d want >=150", s); end
      end
      if (PCM_STB_o === 1'b1) s++;
    end
    checks++; if (!got) begin errors++; $display("FAIL midrst_timeout got no PER_STB want one"); end
  endtask

  task automatic test_hysteresis();
    // 144 and 112 sit exactly on the thresholds and must not switch the detector
    int  k_hi [4] = '{10, 9, 16, 16};
    int  k_lo [4] = '{0, 0, 6, 7};
    bit  fire [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      int nper = 0;
      pat_hi = pat_k(k_hi[i]);
      pat_lo = pat_k(k_lo[i]);
      half = 320;
      mode = 3;
      do_reset();
      for (int k = 0; k < 2100; k++) begin
        step();
        if (PER_STB_o === 1'b1) begin
          nper++;
          checks++; if (PERIODs_o !== 10'd40) begin errors++; $display("FAIL hyst_period case %0d got %0d want 40", i, PERIODs_o); end
        end
      end
      checks++;
      if (fire[i] ? (nper < 2) : (nper != 0)) begin
        errors++;
        $display("FAIL hyst_count case %0d got %0d reports want %s", i, nper, fire[i] ? ">=2" : "0");
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_density();
    test_period();
    test_dropout();
    test_midreset();
    test_hysteresis();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
